// File: rtl/aes_req_arbiter_if.sv
// Signal bundle between two encryption requesters, the AES core and aes_req_arbiter.
// The slave modport is the arbiter's view; master is the requesters/core side.
interface aes_req_arbiter_if;
  logic         req0_valid;
  logic [127:0] req0_data;
  logic [127:0] req0_key;
  logic         req0_ready;
  logic         req1_valid;
  logic [127:0] req1_data;
  logic [127:0] req1_key;
  logic         req1_ready;

  logic         rsp0_valid;
  logic [127:0] rsp0_data;
  logic         rsp0_err;
  logic         rsp1_valid;
  logic [127:0] rsp1_data;
  logic         rsp1_err;

  logic         core_en;
  logic [127:0] core_data_in;
  logic [127:0] core_key_in;
  logic [127:0] core_data_out;
  logic         core_data_out_valid;

  logic         busy;

  modport slave (
    input  req0_valid, req0_data, req0_key,
    input  req1_valid, req1_data, req1_key,
    output req0_ready, req1_ready,
    output rsp0_valid, rsp0_data, rsp0_err,
    output rsp1_valid, rsp1_data, rsp1_err,
    output core_en, core_data_in, core_key_in,
    input  core_data_out, core_data_out_valid,
    output busy
  );

  modport master (
    output req0_valid, req0_data, req0_key,
    output req1_valid, req1_data, req1_key,
    input  req0_ready, req1_ready,
    input  rsp0_valid, rsp0_data, rsp0_err,
    input  rsp1_valid, rsp1_data, rsp1_err,
    input  core_en, core_data_in, core_key_in,
    output core_data_out, core_data_out_valid,
    input  busy
  );
endinterface

// File: rtl/aes_req_arbiter.sv
// Two-requester round-robin front end for a single AES core: one transaction in flight,
// per-requester response registers, and a bounded wait for the core result.
module aes_req_arbiter #(
  parameter int TIMEOUT_CYC = 64
) (
  input  logic             AES_clk,
  input  logic             AES_rst,
  aes_req_arbiter_if.slave bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_RESP = 2'd2;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYC - 1);

  logic [1:0]   state_q;
  logic [1:0]   state_d;
  logic         rr_ptr_q;
  logic         gnt_q;
  logic [15:0]  wait_cnt_q;
  logic [127:0] cap_data_q;
  logic [127:0] cap_key_q;
  logic [127:0] res_data0_q;
  logic [127:0] res_data1_q;
  logic         res_err0_q;
  logic         res_err1_q;

  logic         any_req;
  logic         gnt_idx;
  logic         accept;
  logic         timeout_hit;
  logic         run_done;
  logic [127:0] res_data;
  logic         res_err;

  // Arbitration only happens in IDLE and never while reset is held, so a request
  // that is pending through reset is granted in the first cycle after release.
  assign any_req = bus.req0_valid | bus.req1_valid;
  assign gnt_idx = (bus.req0_valid & bus.req1_valid) ? rr_ptr_q : bus.req1_valid;
  assign accept  = (state_q == ST_IDLE) & any_req & ~AES_rst;

  // A core result arriving on the last allowed cycle beats the timeout.
  assign timeout_hit = (wait_cnt_q == CNT_LAST);
  assign run_done    = (state_q == ST_RUN) & (bus.core_data_out_valid | timeout_hit);
  assign res_data    = bus.core_data_out_valid ? bus.core_data_out : '0;
  assign res_err     = ~bus.core_data_out_valid;

  always_comb begin
    // NOTE: state_d takes a default before the case so no path leaves it unassigned; without it a latch is inferred.
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)   state_d = ST_RUN;
      ST_RUN:  if (run_done) state_d = ST_RESP;
      ST_RESP:               state_d = ST_IDLE;
      default:               state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge AES_clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (AES_rst) begin
      // NOTE: the wide capture/result registers are reset too, because they drive visible outputs that must read zero after reset.
      state_q     <= ST_IDLE;
      rr_ptr_q    <= 1'b0;
      gnt_q       <= 1'b0;
      wait_cnt_q  <= '0;
      cap_data_q  <= '0;
      cap_key_q   <= '0;
      res_data0_q <= '0;
      res_data1_q <= '0;
      res_err0_q  <= 1'b0;
      res_err1_q  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (accept) begin
        gnt_q      <= gnt_idx;
        rr_ptr_q   <= ~gnt_idx;
        wait_cnt_q <= '0;
        cap_data_q <= gnt_idx ? bus.req1_data : bus.req0_data;
        cap_key_q  <= gnt_idx ? bus.req1_key  : bus.req0_key;
      end else if (state_q == ST_RUN) begin
        wait_cnt_q <= wait_cnt_q + 16'd1;
      end

      // Only the granted requester's result registers move; the other side holds.
      if (run_done) begin
        if (gnt_q) begin
          res_data1_q <= res_data;
          res_err1_q  <= res_err;
        end else begin
          res_data0_q <= res_data;
          res_err0_q  <= res_err;
        end
      end
    end
  end

  assign bus.req0_ready = accept & ~gnt_idx;
  assign bus.req1_ready = accept &  gnt_idx;

  // A reset landing in the RESP cycle suppresses the pulse, aborting that response.
  assign bus.rsp0_valid = (state_q == ST_RESP) & ~gnt_q & ~AES_rst;
  assign bus.rsp1_valid = (state_q == ST_RESP) &  gnt_q & ~AES_rst;
  assign bus.rsp0_data  = res_data0_q;
  assign bus.rsp0_err   = res_err0_q;
  assign bus.rsp1_data  = res_data1_q;
  assign bus.rsp1_err   = res_err1_q;

  assign bus.core_en      = (state_q == ST_RUN);
  assign bus.core_data_in = cap_data_q;
  assign bus.core_key_in  = cap_key_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_aes_req_arbiter.sv
// Directed self-checking bench for aes_req_arbiter; the bench plays both requesters and the AES core.
// Inputs change and outputs are sampled around the falling clock edge.
module tb_aes_req_arbiter;

  localparam logic [127:0] JUNK   = 128'hffffffff_eeeeeeee_dddddddd_cccccccc;
  localparam logic [127:0] RD0    = 128'h01234567_89abcdef_fedcba98_76543210;
  localparam logic [127:0] RK0    = 128'h0f0e0d0c_0b0a0908_07060504_03020100;
  localparam logic [127:0] CA     = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;
  localparam logic [127:0] BD     = 128'h0000000d_00000000_00000000_00000000;
  localparam logic [127:0] BK     = 128'haa2bdb40_bff6a5e8_caa9ba3e_bc1e2acc;
  localparam logic [127:0] BC     = 128'h3ad77bb4_0d7a3660_a89ecaf3_2466ef97;
  localparam logic [127:0] D0     = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] K0     = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] D1     = 128'hdeadbeef_cafef00d_12345678_9abcdef0;
  localparam logic [127:0] K1     = 128'h2b7e1516_28aed2a6_abf71588_09cf4f3c;
  localparam logic [127:0] CLIMIT = 128'h8ea2b7ca_516745bf_eafc4990_4b496089;

  logic AES_clk;
  logic AES_rst;
  int   n_checks;
  int   n_fail;

  aes_req_arbiter_if bus ();

  aes_req_arbiter #(.TIMEOUT_CYC(64)) dut (
    .AES_clk (AES_clk),
    .AES_rst (AES_rst),
    .bus     (bus)
  );

  initial AES_clk = 1'b0;
  always #5 AES_clk = ~AES_clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Plays the core from the first RUN cycle; asserts the result strobe on the lat-th
  // core_en cycle (lat=0: never). Returns with the RESP cycle settled.
  task automatic drive_core(input int lat, input logic [127:0] cipher, output int en_cycles);
    en_cycles = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge AES_clk);
      if (!bus.core_en) begin
        bus.core_data_out_valid = 1'b0;
        #1;
        return;
      end
      en_cycles++;
      bus.core_data_out_valid = (en_cycles == lat);
      bus.core_data_out       = (en_cycles == lat) ? cipher : JUNK;
      #1;
    end
    bus.core_data_out_valid = 1'b0;
  endtask

  task automatic test_reset();
    int en;
    AES_rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = RD0; bus.req0_key = RK0;
    bus.req1_valid = 1'b0; bus.req1_data = '0;  bus.req1_key = '0;
    bus.core_data_out_valid = 1'b0; bus.core_data_out = JUNK;
    repeat (2) @(negedge AES_clk);
    #1;
    n_checks++; if (bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready0: got %b want 0", bus.req0_ready); end
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", bus.busy); end
    n_checks++; if (bus.core_en !== 1'b0) begin n_fail++; $display("FAIL reset_core_en: got %b want 0", bus.core_en); end
    n_checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid: got %b%b want 00", bus.rsp1_valid, bus.rsp0_valid); end
    n_checks++; if (bus.rsp0_data !== '0 || bus.rsp1_err !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_regs: data0 %h err1 %b want 0", bus.rsp0_data, bus.rsp1_err); end
    n_checks++; if (bus.core_data_in !== '0 || bus.core_key_in !== '0) begin n_fail++; $display("FAIL reset_core_in: data %h key %h want 0", bus.core_data_in, bus.core_key_in); end
    // Release: req0 has been pending through reset and is granted immediately.
    AES_rst = 1'b0;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL release_grant: ready1/0 %b%b want 01", bus.req1_ready, bus.req0_ready); end
    @(posedge AES_clk); #1 bus.req0_valid = 1'b0;
    drive_core(3, CA, en);
    n_checks++; if (en !== 3) begin n_fail++; $display("FAIL release_run_len: got %0d want 3", en); end
    n_checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_data !== CA) begin n_fail++; $display("FAIL release_rsp0: valid %b data %h want 1 %h", bus.rsp0_valid, bus.rsp0_data, CA); end
    n_checks++; if (bus.core_data_in !== RD0 || bus.core_key_in !== RK0) begin n_fail++; $display("FAIL release_capture: data %h key %h", bus.core_data_in, bus.core_key_in); end
  endtask

  task automatic test_basic();
    int en;
    @(negedge AES_clk);
    bus.req0_valid = 1'b1; bus.req0_data = BD; bus.req0_key = BK;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL basic_accept: ready0 %b busy %b want 1 0", bus.req0_ready, bus.busy); end
    @(posedge AES_clk); #1 bus.req0_valid = 1'b0;
    drive_core(40, BC, en);
    n_checks++; if (en !== 40) begin n_fail++; $display("FAIL basic_core_en_len: got %0d want 40", en); end
    n_checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0) begin n_fail++; $display("FAIL basic_rsp_valid: rsp1/0 %b%b want 01", bus.rsp1_valid, bus.rsp0_valid); end
    n_checks++; if (bus.rsp0_data !== BC || bus.rsp0_err !== 1'b0) begin n_fail++; $display("FAIL basic_rsp0: data %h err %b want %h 0", bus.rsp0_data, bus.rsp0_err, BC); end
    n_checks++; if (bus.core_data_in !== BD || bus.core_key_in !== BK) begin n_fail++; $display("FAIL basic_core_in: data %h key %h", bus.core_data_in, bus.core_key_in); end
    n_checks++; if (bus.rsp1_data !== '0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL basic_other_side: data1 %h busy %b want 0 1", bus.rsp1_data, bus.busy); end
    @(negedge AES_clk); #1;
    n_checks++; if (bus.rsp0_valid !== 1'b0 || bus.busy !== 1'b0 || bus.rsp0_data !== BC) begin n_fail++; $display("FAIL basic_after: valid %b busy %b data %h", bus.rsp0_valid, bus.busy, bus.rsp0_data); end
  endtask

  task automatic test_round_robin();
    int en;
    int lat [4];
    logic [127:0] cph [4];
    lat = '{2, 1, 5, 3};
    cph = '{128'h11111111_0000aaaa_0000bbbb_0000cccc, 128'h22222222_0000dddd_0000eeee_0000ffff,
            128'h33333333_12121212_34343434_56565656, 128'h44444444_78787878_9a9a9a9a_bcbcbcbc};
    @(negedge AES_clk);
    AES_rst = 1'b1;
    bus.req0_valid = 1'b1; bus.req0_data = D0; bus.req0_key = K0;
    bus.req1_valid = 1'b1; bus.req1_data = D1; bus.req1_key = K1;
    @(negedge AES_clk);
    AES_rst = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (k != 0) @(negedge AES_clk);
      #1;
      n_checks++;
      if (bus.req0_ready !== ((k % 2) == 0) || bus.req1_ready !== ((k % 2) == 1)) begin
        n_fail++; $display("FAIL rr_grant%0d: ready1/0 %b%b", k, bus.req1_ready, bus.req0_ready);
      end
      drive_core(lat[k], cph[k], en);
      if (k == 3) begin bus.req0_valid = 1'b0; bus.req1_valid = 1'b0; end
      if ((k % 2) == 0) begin
        n_checks++;
        if (bus.rsp0_valid !== 1'b1 || bus.rsp1_valid !== 1'b0 || bus.rsp0_data !== cph[k] || bus.core_data_in !== D0) begin
          n_fail++; $display("FAIL rr_rsp%0d: v1/0 %b%b data0 %h core_in %h", k, bus.rsp1_valid, bus.rsp0_valid, bus.rsp0_data, bus.core_data_in);
        end
      end else begin
        n_checks++;
        if (bus.rsp1_valid !== 1'b1 || bus.rsp0_valid !== 1'b0 || bus.rsp1_data !== cph[k] || bus.core_key_in !== K1) begin
          n_fail++; $display("FAIL rr_rsp%0d: v1/0 %b%b data1 %h core_key %h", k, bus.rsp1_valid, bus.rsp0_valid, bus.rsp1_data, bus.core_key_in);
        end
      end
      n_checks++; if (en !== lat[k]) begin n_fail++; $display("FAIL rr_run_len%0d: got %0d want %0d", k, en, lat[k]); end
    end
    // Requester 0 must still show its own last result after requester 1's response.
    n_checks++; if (bus.rsp0_data !== cph[2]) begin n_fail++; $display("FAIL rr_hold0: got %h want %h", bus.rsp0_data, cph[2]); end
  endtask

  task automatic test_timeout();
    int en;
    @(negedge AES_clk);
    bus.req1_valid = 1'b1; bus.req1_data = D1 ^ K1; bus.req1_key = K0;
    #1;
    n_checks++; if (bus.req1_ready !== 1'b1 || bus.req0_ready !== 1'b0) begin n_fail++; $display("FAIL to_accept: ready1/0 %b%b want 10", bus.req1_ready, bus.req0_ready); end
    @(posedge AES_clk); #1 bus.req1_valid = 1'b0;
    drive_core(0, '0, en);
    n_checks++; if (en !== 64) begin n_fail++; $display("FAIL to_run_len: got %0d want 64", en); end
    n_checks++; if (bus.rsp1_valid !== 1'b1 || bus.rsp1_err !== 1'b1 || bus.rsp1_data !== '0) begin n_fail++; $display("FAIL to_rsp1: valid %b err %b data %h want 1 1 0", bus.rsp1_valid, bus.rsp1_err, bus.rsp1_data); end
    n_checks++; if (bus.rsp0_valid !== 1'b0 || bus.rsp0_data !== 128'h33333333_12121212_34343434_56565656) begin n_fail++; $display("FAIL to_other_side: valid0 %b data0 %h", bus.rsp0_valid, bus.rsp0_data); end
  endtask

  task automatic test_valid_at_limit();
    int en;
    @(negedge AES_clk);
    bus.req0_valid = 1'b1; bus.req0_data = D1; bus.req0_key = K1;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL lim_accept: got %b want 1", bus.req0_ready); end
    @(posedge AES_clk); #1 bus.req0_valid = 1'b0;
    drive_core(64, CLIMIT, en);
    n_checks++; if (en !== 64) begin n_fail++; $display("FAIL lim_run_len: got %0d want 64", en); end
    n_checks++; if (bus.rsp0_valid !== 1'b1 || bus.rsp0_err !== 1'b0 || bus.rsp0_data !== CLIMIT) begin n_fail++; $display("FAIL lim_rsp0: valid %b err %b data %h", bus.rsp0_valid, bus.rsp0_err, bus.rsp0_data); end
  endtask

  task automatic test_idle_valid();
    @(negedge AES_clk);
    for (int i = 0; i < 3; i++) begin
      @(negedge AES_clk);
      bus.core_data_out_valid = 1'b1; bus.core_data_out = JUNK;
      #1;
      n_checks++;
      if (bus.busy !== 1'b0 || bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0) begin
        n_fail++; $display("FAIL idle_strobe%0d: busy %b rsp1/0 %b%b want 0 00", i, bus.busy, bus.rsp1_valid, bus.rsp0_valid);
      end
    end
    @(negedge AES_clk);
    bus.core_data_out_valid = 1'b0;
    #1;
    n_checks++; if (bus.busy !== 1'b0 || bus.rsp0_data !== CLIMIT || bus.rsp1_data !== '0) begin n_fail++; $display("FAIL idle_after: busy %b data0 %h data1 %h", bus.busy, bus.rsp0_data, bus.rsp1_data); end
  endtask

  task automatic test_reset_abort();
    bit saw_rsp;
    @(negedge AES_clk);
    bus.req0_valid = 1'b1; bus.req0_data = D0; bus.req0_key = K0;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1) begin n_fail++; $display("FAIL abort_accept: got %b want 1", bus.req0_ready); end
    @(posedge AES_clk); #1 bus.req0_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge AES_clk);
      if (i == 10) AES_rst = 1'b1;
    end
    #1;
    n_checks++; if (bus.core_en !== 1'b1) begin n_fail++; $display("FAIL abort_in_run: core_en %b want 1", bus.core_en); end
    @(negedge AES_clk);
    AES_rst = 1'b0;
    #1;
    n_checks++; if (bus.core_en !== 1'b0 || bus.busy !== 1'b0) begin n_fail++; $display("FAIL abort_state: core_en %b busy %b want 0 0", bus.core_en, bus.busy); end
    n_checks++; if (bus.rsp0_data !== '0 || bus.core_data_in !== '0) begin n_fail++; $display("FAIL abort_cleared: data0 %h core_in %h want 0", bus.rsp0_data, bus.core_data_in); end
    saw_rsp = 1'b0;
    for (int i = 0; i < 70; i++) begin
      @(negedge AES_clk); #1;
      if (bus.rsp0_valid !== 1'b0 || bus.rsp1_valid !== 1'b0 || bus.busy !== 1'b0) saw_rsp = 1'b1;
    end
    n_checks++; if (saw_rsp) begin n_fail++; $display("FAIL abort_no_rsp: response or busy seen after abort"); end
    // rr_ptr was left pointing at requester 1 before the abort; reset must return it to 0.
    @(negedge AES_clk);
    bus.req0_valid = 1'b1; bus.req1_valid = 1'b1;
    #1;
    n_checks++; if (bus.req0_ready !== 1'b1 || bus.req1_ready !== 1'b0) begin n_fail++; $display("FAIL abort_rr_ptr: ready1/0 %b%b want 01", bus.req1_ready, bus.req0_ready); end
    @(posedge AES_clk); #1;
    bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    test_reset();
    test_basic();
    test_round_robin();
    test_timeout();
    test_valid_at_limit();
    test_idle_valid();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
